// File: rtl/fu_mc_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fu_mc_if
// Purpose  : Request/response bundle between the operand source and fu_mc.
// Revision : 1.0  initial release
// ============================================================================
interface fu_mc_if #(
  parameter int DW = 16
);
  logic          start_in;
  logic [3:0]    fs_in;
  logic [DW-1:0] a_in;
  logic [DW-1:0] b_in;
  logic          ready_out;
  logic          done_out;
  logic [DW-1:0] f_out;
  logic          z_out;
  logic          n_out;
  logic          v_out;

  modport master (
    output start_in, fs_in, a_in, b_in,
    input  ready_out, done_out, f_out, z_out, n_out, v_out
  );

  modport slave (
    input  start_in, fs_in, a_in, b_in,
    output ready_out, done_out, f_out, z_out, n_out, v_out
  );
endinterface
`default_nettype wire

// File: rtl/fu_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fu_mc
// Purpose  : Registered multi-cycle function unit; single-cycle ALU ops and
//            an iterative signed shift-add multiplier with optional saturation.
// Revision : 1.0  initial release
// ============================================================================
module fu_mc #(
  parameter int DW     = 16,
  parameter bit SAT_EN = 1'b1
) (
  input  wire logic clk,
  input  wire logic rst,
  fu_mc_if.slave    bus
);

  localparam int CW = $clog2(DW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [3:0] OP_MOVA = 4'd0;
  localparam logic [3:0] OP_INC  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_DEC  = 4'd6;
  localparam logic [3:0] OP_SLA  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_MOVB = 4'd12;
  localparam logic [3:0] OP_SHR  = 4'd13;
  localparam logic [3:0] OP_SHL  = 4'd14;
  localparam logic [3:0] OP_CLR  = 4'd15;

  localparam logic [DW-1:0]   ZERO   = '0;
  localparam logic [DW-1:0]   ONE    = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]   SMAX   = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]   SMIN   = {1'b1, {(DW-1){1'b0}}};
  localparam logic [2*DW-1:0] ZERO2  = '0;
  localparam logic [CW-1:0]   LAST   = CW'(DW - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic            ready;

  logic [DW-1:0]   a;
  logic [DW-1:0]   b;
  logic [3:0]      fs;
  logic            start;

  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] mcand;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            sign;

  logic [DW-1:0]   f_q;
  logic            z_q;
  logic            n_q;
  logic            v_q;
  logic            done_q;

  logic [DW-1:0]   alu_f;
  logic            alu_v;
  logic [DW-1:0]   a_mag;
  logic [DW-1:0]   b_mag;
  logic [2*DW-1:0] prod;
  logic [DW:0]     prod_hi;
  logic            mul_v;
  logic [DW-1:0]   mul_f;

  assign a     = bus.a_in;
  assign b     = bus.b_in;
  assign fs    = bus.fs_in;
  assign start = bus.start_in;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && fs == OP_MUL) state_nxt = MUL;
      MUL:     if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready         = (state == IDLE);
    bus.ready_out = ready;
    bus.done_out  = done_q;
    bus.f_out     = f_q;
    bus.z_out     = z_q;
    bus.n_out     = n_q;
    bus.v_out     = v_q;
  end

  // Single-cycle ALU, evaluated on the accepting edge
  always_comb begin
    alu_f = ZERO;
    alu_v = 1'b0;
    case (fs)
      OP_MOVA: alu_f = a;
      OP_INC: begin
        alu_f = a + ONE;
        alu_v = ~a[DW-1] & alu_f[DW-1];
      end
      OP_ADD: begin
        alu_f = a + b;
        alu_v = (a[DW-1] == b[DW-1]) && (alu_f[DW-1] != a[DW-1]);
      end
      OP_SRA:  alu_f = $unsigned($signed(b) >>> 1);
      OP_SUB: begin
        alu_f = a - b;
        alu_v = (a[DW-1] != b[DW-1]) && (alu_f[DW-1] != a[DW-1]);
      end
      OP_DEC: begin
        alu_f = a - ONE;
        alu_v = a[DW-1] & ~alu_f[DW-1];
      end
      OP_SLA: begin
        alu_f = b << 1;
        alu_v = b[DW-1] ^ b[DW-2];
      end
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_XOR:  alu_f = a ^ b;
      OP_NOT:  alu_f = ~a;
      OP_MOVB: alu_f = b;
      OP_SHR:  alu_f = b >> 1;
      OP_SHL:  alu_f = b << 1;
      OP_CLR:  alu_f = ZERO;
      default: alu_f = ZERO;
    endcase
  end

  // Magnitudes stay DW wide: |-2^(DW-1)| = 2^(DW-1) is representable unsigned
  always_comb begin
    a_mag = a[DW-1] ? (ZERO - a) : a;
    b_mag = b[DW-1] ? (ZERO - b) : b;
  end

  // Product fits in the signed range only if bits [2DW-1:DW-1] agree
  always_comb begin
    prod    = sign ? (ZERO2 - acc) : acc;
    prod_hi = prod[2*DW-1:DW-1];
    mul_v   = ~((&prod_hi) | ~(|prod_hi));
    if (SAT_EN && mul_v) begin
      mul_f = prod[2*DW-1] ? SMIN : SMAX;
    end else begin
      mul_f = prod[DW-1:0];
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= ZERO2;
      mcand  <= ZERO2;
      mplier <= ZERO;
      cnt    <= '0;
      sign   <= 1'b0;
      f_q    <= ZERO;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (fs == OP_MUL) begin
              mcand  <= {ZERO, a_mag};
              mplier <= b_mag;
              acc    <= ZERO2;
              cnt    <= '0;
              sign   <= a[DW-1] ^ b[DW-1];
            end else begin
              f_q    <= alu_f;
              z_q    <= (alu_f == ZERO);
              n_q    <= alu_f[DW-1];
              v_q    <= alu_v;
              done_q <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_ONE;
        end
        FIN: begin
          f_q    <= mul_f;
          z_q    <= (mul_f == ZERO);
          n_q    <= mul_f[DW-1];
          v_q    <= mul_v;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fu_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fu_mc
// Purpose  : Directed and randomised scoreboard bench for fu_mc.
// Revision : 1.0  initial release
// ============================================================================
module tb_fu_mc;

  typedef struct packed {
    logic [15:0] f;
    logic        z;
    logic        n;
    logic        v;
  } exp16_t;

  typedef struct packed {
    logic [7:0] f;
    logic       z;
    logic       n;
    logic       v;
  } exp8_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   run16    = 0;
  int   max16    = 0;

  exp16_t q16[$];
  string  t16[$];
  exp16_t qn[$];
  string  tn[$];
  exp8_t  q8[$];
  string  t8[$];

  always #5 clk = ~clk;

  fu_mc_if #(.DW(16)) i16 ();
  fu_mc_if #(.DW(16)) in16 ();
  fu_mc_if #(.DW(8))  i8 ();

  fu_mc #(.DW(16), .SAT_EN(1'b1)) u16  (.clk(clk), .rst(rst), .bus(i16));
  fu_mc #(.DW(16), .SAT_EN(1'b0)) un16 (.clk(clk), .rst(rst), .bus(in16));
  fu_mc #(.DW(8),  .SAT_EN(1'b1)) u8   (.clk(clk), .rst(rst), .bus(i8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model for DW=16, using wide integer arithmetic
  function automatic logic [16:0] model16(input logic [3:0] fs, input logic [15:0] a,
                                          input logic [15:0] b, input bit sat);
    longint sa, sb, r;
    logic [15:0] f;
    logic v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 0; f = 16'h0; v = 1'b0;
    case (fs)
      4'd0:  f = a;
      4'd1:  begin r = sa + 1;  f = r[15:0]; v = (r > 32767) || (r < -32768); end
      4'd2:  begin r = sa + sb; f = r[15:0]; v = (r > 32767) || (r < -32768); end
      4'd3:  begin
        r = sa * sb;
        v = (r > 32767) || (r < -32768);
        f = (sat && v) ? ((r < 0) ? 16'h8000 : 16'h7FFF) : r[15:0];
      end
      4'd4:  f = {b[15], b[15:1]};
      4'd5:  begin r = sa - sb; f = r[15:0]; v = (r > 32767) || (r < -32768); end
      4'd6:  begin r = sa - 1;  f = r[15:0]; v = (r > 32767) || (r < -32768); end
      4'd7:  begin f = {b[14:0], 1'b0}; v = b[15] ^ b[14]; end
      4'd8:  f = a & b;
      4'd9:  f = a | b;
      4'd10: f = a ^ b;
      4'd11: f = ~a;
      4'd12: f = b;
      4'd13: f = {1'b0, b[15:1]};
      4'd14: f = {b[14:0], 1'b0};
      default: f = 16'h0;
    endcase
    return {f, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue16(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] ef, input logic ev, input bit push, input string tag);
    int n = 0;
    while (i16.ready_out !== 1'b1 && n < 100) begin step(); n++; end
    chk({tag, "_ready_wait"}, n < 100, 1);
    i16.start_in = 1'b1; i16.fs_in = fs; i16.a_in = a; i16.b_in = b;
    if (push) begin
      q16.push_back('{f: ef, z: (ef == 16'h0), n: ef[15], v: ev});
      t16.push_back(tag);
    end
    step();
    i16.start_in = 1'b0;
  endtask

  task automatic drain16(input string tag);
    int n = 0;
    while ((q16.size() != 0 || i16.ready_out !== 1'b1) && n < 200) begin step(); n++; end
    chk({tag, "_drain"}, q16.size(), 0);
  endtask

  // Scoreboard monitors, sampled on the falling edge
  always @(negedge clk) begin
    exp16_t e;
    string  t;
    run16 = (i16.done_out === 1'b1) ? run16 + 1 : 0;
    if (run16 > max16) max16 = run16;
    if (i16.done_out === 1'b1) begin
      chk("u16_done_expected", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        t = t16.pop_front();
        chk({t, "_f"}, i16.f_out, e.f);
        chk({t, "_znv"}, {i16.z_out, i16.n_out, i16.v_out}, {e.z, e.n, e.v});
      end
    end
  end

  always @(negedge clk) begin
    exp16_t e;
    string  t;
    if (in16.done_out === 1'b1) begin
      chk("un16_done_expected", qn.size() > 0, 1);
      if (qn.size() > 0) begin
        e = qn.pop_front();
        t = tn.pop_front();
        chk({t, "_f"}, in16.f_out, e.f);
        chk({t, "_znv"}, {in16.z_out, in16.n_out, in16.v_out}, {e.z, e.n, e.v});
      end
    end
  end

  always @(negedge clk) begin
    exp8_t e;
    string t;
    if (i8.done_out === 1'b1) begin
      chk("u8_done_expected", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        t = t8.pop_front();
        chk({t, "_f"}, i8.f_out, e.f);
        chk({t, "_znv"}, {i8.z_out, i8.n_out, i8.v_out}, {e.z, e.n, e.v});
      end
    end
  end

  initial begin
    int lowc;
    int n;
    logic [16:0] m;
    logic [3:0]  rfs;
    logic [15:0] ra, rb;

    i16.start_in = 1'b0;  i16.fs_in = 4'd0;  i16.a_in = '0;  i16.b_in = '0;
    in16.start_in = 1'b0; in16.fs_in = 4'd0; in16.a_in = '0; in16.b_in = '0;
    i8.start_in = 1'b0;   i8.fs_in = 4'd0;   i8.a_in = '0;   i8.b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_ready", i16.ready_out, 1);
    chk("rst_done", i16.done_out, 0);
    chk("rst_f", i16.f_out, 0);
    chk("rst_znv", {i16.z_out, i16.n_out, i16.v_out}, 0);
    chk("rst_u8_ready", i8.ready_out, 1);

    // Saturating multiply with latency and handshake observation
    issue16(4'd3, 16'd300, 16'd200, 16'h7FFF, 1'b1, 1, "mul_pos_sat");
    lowc = 0;
    while (i16.ready_out !== 1'b1 && lowc < 100) begin step(); lowc++; end
    chk("mul_ready_low_cycles", lowc, 17);
    chk("mul_done_at_edge17", i16.done_out, 1);
    step();
    chk("mul_done_one_cycle", i16.done_out, 0);

    issue16(4'd3, 16'hFED4, 16'd200, 16'h8000, 1'b1, 1, "mul_neg_sat");
    drain16("mul_neg_sat");
    issue16(4'd3, 16'd7, 16'hFFFD, 16'hFFEB, 1'b0, 1, "mul_7xm3");
    drain16("mul_7xm3");
    issue16(4'd3, 16'h8000, 16'd1, 16'h8000, 1'b0, 1, "mul_min_x1");
    drain16("mul_min_x1");
    issue16(4'd3, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1, "mul_zero");
    drain16("mul_zero");

    // Back-to-back single-cycle operations
    max16 = 0;
    issue16(4'd2, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1, "add_ovf");
    issue16(4'd5, 16'd5, 16'd5, 16'h0000, 1'b0, 1, "sub_zero");
    issue16(4'd11, 16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1, "not_ffff");
    drain16("b2b");
    chk("b2b_done_run", max16, 3);

    // Request while busy is ignored
    issue16(4'd3, 16'd7, 16'hFFFD, 16'hFFEB, 1'b0, 1, "mul_busy");
    step(); step();
    i16.start_in = 1'b1; i16.fs_in = 4'd2; i16.a_in = 16'd1; i16.b_in = 16'd1;
    step();
    i16.start_in = 1'b0; i16.a_in = 16'h1234; i16.b_in = 16'h5678;
    drain16("mul_busy");

    // Reset in the middle of a multiply
    issue16(4'd3, 16'd300, 16'd200, 16'h0, 1'b0, 0, "mul_abort");
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", i16.ready_out, 1);
    chk("abort_f", i16.f_out, 0);
    chk("abort_znv", {i16.z_out, i16.n_out, i16.v_out}, 0);
    chk("abort_done", i16.done_out, 0);
    repeat (20) step();
    issue16(4'd2, 16'd2, 16'd3, 16'd5, 1'b0, 1, "add_after_abort");
    drain16("add_after_abort");

    // Shift boundaries
    issue16(4'd4, 16'h0000, 16'h8002, 16'hC001, 1'b0, 1, "sra");
    issue16(4'd7, 16'h0000, 16'h4000, 16'h8000, 1'b1, 1, "sla_ovf");
    issue16(4'd13, 16'h0000, 16'h8001, 16'h4000, 1'b0, 1, "shr");
    issue16(4'd6, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1, "dec_ovf");
    issue16(4'd1, 16'h7FFF, 16'h0000, 16'h8000, 1'b1, 1, "inc_ovf");
    drain16("shifts");

    // Non-saturating and narrow instances
    in16.start_in = 1'b1; in16.fs_in = 4'd3; in16.a_in = 16'd300; in16.b_in = 16'd200;
    qn.push_back('{f: 16'hEA60, z: 1'b0, n: 1'b1, v: 1'b1});
    tn.push_back("nosat_mul");
    i8.start_in = 1'b1; i8.fs_in = 4'd3; i8.a_in = 8'd12; i8.b_in = 8'd12;
    q8.push_back('{f: 8'h7F, z: 1'b0, n: 1'b0, v: 1'b1});
    t8.push_back("dw8_mul");
    step();
    in16.start_in = 1'b0;
    i8.start_in = 1'b0;
    n = 0;
    while ((qn.size() != 0 || q8.size() != 0) && n < 100) begin step(); n++; end
    chk("aux_drain", qn.size() + q8.size(), 0);

    // Randomised operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rfs = 4'($urandom_range(0, 15));
      ra  = (i % 5 == 0) ? 16'h8000 : 16'($urandom);
      rb  = (i % 7 == 0) ? 16'hFFFF : 16'($urandom);
      m   = model16(rfs, ra, rb, 1'b1);
      issue16(rfs, ra, rb, m[16:1], m[0], 1, "rand");
    end
    drain16("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fu_mc.md
Name: fu_mc

Overview:
- Parametrised, registered, multi-cycle successor to the combinational 16-bit function unit in mycpu.
- Same 4-bit function-select encoding, generalised to DW bits.
- Adds a start/ready/done handshake, an iterative signed shift-add multiplier with optional saturation, and an overflow flag.
- Sits between register-file read ports and the write-back mux; the control FSM stalls on ready_out.

Parameters:
- DW, 16, datapath width in bits; legal values 4..32.
- SAT_EN, 1, 1 = FMUL saturates to signed range; 0 = FMUL returns low DW bits of the product.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start_in  in  1  request; accepted only when ready_out=1.
- fs_in  in  4  function select, sampled on the accepting edge.
- a_in  in  DW  operand A, sampled on the accepting edge.
- b_in  in  DW  operand B, sampled on the accepting edge.
- ready_out  out  1  unit idle, can accept a request.
- done_out  out  1  one-cycle pulse: f/z/n/v are freshly valid.
- f_out  out  DW  result, held until the next completion.
- z_out  out  1  f_out == 0.
- n_out  out  1  f_out[DW-1].
- v_out  out  1  signed overflow or saturation occurred.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, ready_out=1, done_out=0, f_out=0, z_out=0, n_out=0, v_out=0.
- Reset mid-operation aborts the operation; no done_out is produced.
- FSM states: IDLE, MUL, FIN.
  - IDLE: start_in & ready_out is an accepting edge.
  - Non-FMUL opcode: the result is computed combinationally and f/z/n/v are registered on the accepting edge. done_out=1 for the following cycle. State stays IDLE. Latency 1; back-to-back accepts allowed every cycle.
  - FMUL opcode: the accepting edge latches |a|, |b| and sign=a[DW-1]^b[DW-1], clears a 2*DW-bit accumulator and the counter, sets ready_out=0, and moves to MUL.
  - MUL: one shift-add iteration per edge over the multiplier bits, LSB first. After exactly DW iterations, moves to FIN.
  - FIN: negates the magnitude if sign=1, then applies saturation. Registers f/z/n/v, pulses done_out, sets ready_out=1, and returns to IDLE. Outputs update on edge DW+1 after the accepting edge.
- start_in while ready_out=0 is ignored; no queueing. Operand and fs changes while busy have no effect.
- done_out is never high for two consecutive cycles from the same request.
- Opcodes (fs_in → f_out; all arithmetic is modulo 2^DW unless saturated):
  - 0 MOVA: a
  - 1 INC: a+1
  - 2 ADD: a+b
  - 3 MUL: a*b, signed
  - 4 SRA: b>>>1
  - 5 SUB: a-b
  - 6 DEC: a-1
  - 7 SLA: b<<<1
  - 8 AND: a&b
  - 9 OR: a|b
  - 10 XOR: a^b
  - 11 NOT: ~a
  - 12 MOVB: b
  - 13 SHR: b>>1
  - 14 SHL: b<<1
  - 15 CLR: 0
- Flags z_out and n_out are always derived from the final f_out.
- v_out:
  - INC, ADD, SUB, DEC: signed two's-complement overflow.
  - SLA: b[DW-1] != b[DW-2].
  - MUL: set when the true product lies outside [-2^(DW-1), 2^(DW-1)-1], for both SAT_EN values.
  - All other opcodes: 0.
- Saturation (SAT_EN=1):
  - Positive overflow gives 2^(DW-1)-1.
  - Negative overflow gives -2^(DW-1).
  - The product -2^(DW-1)*1 is exact, so v=0.
- Magnitude of -2^(DW-1) is 2^(DW-1), which fits in DW unsigned bits. No width loss is allowed.
- If either operand of FMUL is 0, the result is 0, z=1, n=0, v=0, and latency stays DW+1.

Test Plan:
- DW=16, SAT_EN=1: reset, then MUL a=300, b=200 → after 17 edges f=0x7FFF, v=1, n=0, z=0. done_out high exactly 1 cycle; ready_out low for 17 cycles.
- MUL a=-300, b=200 → f=0x8000, v=1, n=1. MUL a=7, b=-3 → f=0xFFEB, n=1, v=0. MUL a=0x8000, b=1 → f=0x8000, v=0. With SAT_EN=0, 300*200 → f=0xEA60, v=1.
- Back-to-back single-cycle ops: ADD 0x7FFF+1 → f=0x8000, v=1, n=1. Next cycle SUB 5-5 → f=0, z=1, v=0. Next cycle NOT 0xFFFF → f=0, z=1. done_out is high on three consecutive cycles.
- During MUL, pulse start_in with ADD 1+1 → ignored; only the MUL result appears, with a single done_out.
- Assert rst at MUL iteration 8 → next cycle ready_out=1, f/z/n/v=0, no done_out. A new ADD 2+3 completes with f=5.
- Shifts: SRA b=0x8002 → 0xC001. SLA b=0x4000 → 0x8000, v=1. SHR b=0x8001 → 0x4000. DW=8 regression: MUL 12*12 → 0x7F, v=1.
